// File: rtl/load_align_unit.sv
// Load alignment unit: fetches one or two memory words, extracts the addressed byte/half/word and extends it.
// Optional macro LOAD_ALIGN_MISALIGNED_EN enables word-crossing loads; without it they fault.
module load_align_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_fault
);

    typedef enum logic [2:0] {IDLE, RD0, RD1, WAIT1, RESP} state_t;

    localparam logic [ADDR_WIDTH-3:0] WORD_ONE = (ADDR_WIDTH-2)'(1);

    state_t                  state_reg;
    logic [2:0]              funct3_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [TAG_WIDTH-1:0]    tag_reg;
    logic [31:0]             word0_reg;
    logic                    mem_re_reg;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg;
    logic                    rsp_valid_reg;
    logic [31:0]             rsp_data_reg;
    logic [TAG_WIDTH-1:0]    rsp_tag_reg;
    logic                    rsp_fault_reg;

    function automatic logic is_illegal(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic needs_split(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == 3'b001 || f3 == 3'b101) && off == 2'd3) ||
               (f3 == 3'b010 && off != 2'd0);
    endfunction

    // w1 only ever contributes its low three bytes, since at most three bytes spill into the second word
    function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [23:0] w1,
                                               input logic [31:0] w0);
        logic [31:0] w;
        logic [31:0] r;
        w = w0;
        r = 32'd0;
        case (off)
            2'd1:    w = {w1[7:0],  w0[31:8]};
            2'd2:    w = {w1[15:0], w0[31:16]};
            2'd3:    w = {w1[23:0], w0[31:24]};
            default: w = w0;
        endcase
        case (f3)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b010:  r = w;
            3'b100:  r = {24'd0, w[7:0]};
            3'b101:  r = {16'd0, w[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    logic                  req_fault;
    logic                  cur_split;
    logic [ADDR_WIDTH-1:0] word1_addr;

`ifdef LOAD_ALIGN_MISALIGNED_EN
    assign req_fault = is_illegal(req_funct3);
`else
    // Without the split path, any load that would cross a word boundary is rejected up front
    assign req_fault = is_illegal(req_funct3) || needs_split(req_funct3, req_addr[1:0]);
`endif

    assign cur_split  = needs_split(funct3_reg, addr_reg[1:0]);
    assign word1_addr = {addr_reg[ADDR_WIDTH-1:2] + WORD_ONE, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            funct3_reg    <= 3'd0;
            addr_reg      <= '0;
            tag_reg       <= '0;
            word0_reg     <= 32'd0;
            mem_re_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            rsp_tag_reg   <= '0;
            rsp_fault_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        tag_reg    <= req_tag;
                        if (req_fault) begin
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_data_reg  <= 32'd0;
                            rsp_tag_reg   <= req_tag;
                            rsp_fault_reg <= 1'b1;
                        end else begin
                            state_reg    <= RD0;
                            mem_re_reg   <= 1'b1;
                            mem_addr_reg <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        end
                    end
                end
                RD0: begin
                    state_reg <= RD1;
                    // The second read is issued while the first word is arriving
                    if (cur_split) begin
                        mem_re_reg   <= 1'b1;
                        mem_addr_reg <= word1_addr;
                    end else begin
                        mem_re_reg   <= 1'b0;
                        mem_addr_reg <= '0;
                    end
                end
                RD1: begin
                    word0_reg    <= mem_rdata;
                    mem_re_reg   <= 1'b0;
                    mem_addr_reg <= '0;
                    if (cur_split) begin
                        state_reg <= WAIT1;
                    end else begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_data_reg  <= align_load(funct3_reg, addr_reg[1:0], 24'd0, mem_rdata);
                        rsp_tag_reg   <= tag_reg;
                        rsp_fault_reg <= 1'b0;
                    end
                end
                WAIT1: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_data_reg  <= align_load(funct3_reg, addr_reg[1:0], mem_rdata[23:0], word0_reg);
                    rsp_tag_reg   <= tag_reg;
                    rsp_fault_reg <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign mem_re    = mem_re_reg;
    assign mem_addr  = mem_addr_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_tag   = rsp_tag_reg;
    assign rsp_fault = rsp_fault_reg;

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: byte-level memory model, directed loads, reset abort and random loads.
// Follows LOAD_ALIGN_MISALIGNED_EN the same way as the design.
module tb_load_align_unit;

    localparam int AW = 32;
    localparam int TW = 5;
`ifdef LOAD_ALIGN_MISALIGNED_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_funct3 = 3'd0;
    logic [AW-1:0] req_addr = '0;
    logic [TW-1:0] req_tag = '0;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          rsp_fault;

    always #5 clk = ~clk;

    load_align_unit #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_tag(req_tag),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_fault(rsp_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] mem [256];
    logic [31:0] rd_q[$];

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        return 8'(mem[a[9:2]] >> (8 * a[1:0]));
    endfunction

    function automatic bit crosses_word(input logic [2:0] f3, input logic [31:0] a);
        int nbytes;
        nbytes = (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
        return (int'(a[1:0]) + nbytes) > 4;
    endfunction

    function automatic bit model_fault(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
        return !SPLIT_EN && crosses_word(f3, a);
    endfunction

    function automatic logic [31:0] model_data(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        if (model_fault(f3, a)) return 32'd0;
        b0 = byte_at(a);
        b1 = byte_at(a + 32'd1);
        b2 = byte_at(a + 32'd2);
        b3 = byte_at(a + 32'd3);
        case (f3)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd2:    return {b3, b2, b1, b0};
            3'd4:    return {24'd0, b0};
            default: return {16'd0, b1, b0};
        endcase
    endfunction

    // Memory responder: a read strobe seen in one cycle returns data the next; otherwise noise
    initial begin
        logic        re;
        logic [31:0] a;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            re = mem_re;
            a  = mem_addr;
            if (re) rd_q.push_back(a);
            else    check("idle_mem_addr", a, 0);
            @(posedge clk);
            #1;
            mem_rdata = re ? mem[a[9:2]] : $urandom;
        end
    end

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [TW-1:0] tag, input int hold);
        bit          e_fault;
        bit          e_split;
        logic [31:0] e_data;
        int          e_lat;
        int          e_nrd;
        int          lat;
        int          k;
        e_fault = model_fault(f3, a);
        e_split = !e_fault && crosses_word(f3, a);
        e_data  = model_data(f3, a);
        e_lat   = e_fault ? 0 : (e_split ? 3 : 2);
        e_nrd   = e_fault ? 0 : (e_split ? 2 : 1);
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_idle", req_ready, 1);
        if (!req_ready) return;
        rd_q.delete();
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_addr   = a;
        req_tag    = tag;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, e_lat);
        if (!rsp_valid) return;
        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid_hold", rsp_valid, 1);
            check("rsp_data", rsp_data, e_data);
            check("rsp_fault", rsp_fault, e_fault);
            check("rsp_tag", rsp_tag, tag);
            check("req_ready_busy", req_ready, 0);
            if (h == hold) rsp_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
        check("rsp_valid_done", rsp_valid, 0);
        check("req_ready_done", req_ready, 1);
        check("mem_reads", rd_q.size(), e_nrd);
        if (e_nrd >= 1 && rd_q.size() >= 1) check("rd_addr0", rd_q[0], {a[31:2], 2'b00});
        if (e_nrd >= 2 && rd_q.size() >= 2) check("rd_addr1", rd_q[1], {a[31:2], 2'b00} + 32'd4);
        $display("txn f3=%0d addr=%08h tag=%0d data=%08h fault=%0d lat=%0d hold=%0d",
                 f3, a, tag, rsp_data, rsp_fault, lat, hold);
    endtask

    initial begin
        int          abort_edges;
        logic [31:0] abort_addr;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_fault", rsp_fault, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mem[32'h100 >> 2] = 32'hDEADBEEF;
        do_load(3'd2, 32'h100, 5'd3, 0);
        check("lw_value", rsp_data, 32'hDEADBEEF);
        mem[32'h100 >> 2] = 32'h80112233;
        do_load(3'd0, 32'h103, 5'd4, 0);
        check("lb_value", rsp_data, 32'hFFFFFF80);
        do_load(3'd4, 32'h103, 5'd5, 0);
        check("lbu_value", rsp_data, 32'h00000080);
        mem[32'h200 >> 2] = 32'hAB000000;
        mem[32'h204 >> 2] = 32'h000000CD;
        do_load(3'd1, 32'h203, 5'd7, 0);
        check("lh_split_value", rsp_data, SPLIT_EN ? 32'hFFFFCDAB : 32'h0);
        do_load(3'd3, 32'h100, 5'd9, 0);
        do_load(3'd2, 32'h100, 5'd12, 5);
        do_load(3'd2, 32'hFFFF_FFFE, 5'd1, 1);
        do_load(3'd5, 32'h201, 5'd2, 0);

        // Abort a load mid-flight; the late memory word must not leak into the next result
        abort_addr  = SPLIT_EN ? 32'h101 : 32'h100;
        abort_edges = SPLIT_EN ? 2 : 1;
        @(negedge clk);
        req_valid  = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = abort_addr;
        req_tag    = 5'd21;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (abort_edges) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_req_ready", req_ready, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_mem_re", mem_re, 0);
        check("abort_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_abort_rsp_valid", rsp_valid, 0);
        mem[32'h100 >> 2] = 32'h13579BDF;
        do_load(3'd2, 32'h100, 5'd22, 0);
        check("post_abort_lw", rsp_data, 32'h13579BDF);

        for (int t = 0; t < 60; t++) begin
            logic [31:0] ra;
            ra = (t % 10 == 9) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : 32'($urandom_range(0, 1023));
            do_load(3'($urandom_range(0, 7)), ra, 5'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
